// File: rtl/machine_seq_detect.sv
// Serial pattern recogniser: compares the last LEN accepted bits against a
// loadable pattern, reports match progress and keeps a saturating match count.
module machine_seq_detect #(
   parameter int              LEN     = 4,
   parameter int              OVERLAP = 1,
   parameter int              CNT_W   = 8,
   parameter logic [LEN-1:0]  RST_PAT = 4'b1011,
   localparam int             SW      = $clog2(LEN + 1)
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             x,
   input  logic             EN,
   input  logic             LOAD,
   input  logic [LEN-1:0]   PAT_IN,
   input  logic             CLR_CNT,
   output logic             F,
   output logic [SW-1:0]    S,
   output logic [CNT_W-1:0] COUNT,
   output logic             SAT
);

   logic [LEN-1:0]   pat_r, hist_r;
   logic [SW-1:0]    fill_r, s_r;
   logic             f_r, sat_r;
   logic [CNT_W-1:0] count_r;

   logic [LEN-1:0]   pat_d_s, hist_d_s, hist_nx_s;
   logic [SW-1:0]    fill_d_s, fill_nx_s, s_d_s;
   logic             f_d_s, hit_s;

   // Longest pattern prefix that ends the valid part of the history.
   function automatic logic [SW-1:0] progress(input logic [LEN-1:0] h,
                                              input logic [LEN-1:0] p,
                                              input logic [SW-1:0]  f);
      logic [SW-1:0]  best;
      logic [LEN-1:0] mask;
      best = '0;
      for (int k = 1; k <= LEN; k++) begin
         mask = {LEN{1'b1}} >> (LEN - k);
         if ((SW'(k) <= f) && ((h & mask) == (p >> (LEN - k)))) begin
            best = SW'(k);
         end else begin
            best = best;
         end
      end
      return best;
   endfunction

   // Next-state for pattern, history, fill, progress and match pulse.
   always_comb begin
      pat_d_s   = pat_r;
      hist_d_s  = hist_r;
      fill_d_s  = fill_r;
      s_d_s     = s_r;
      f_d_s     = 1'b0;
      hit_s     = 1'b0;
      hist_nx_s = {hist_r[LEN-2:0], x};
      fill_nx_s = (fill_r == SW'(LEN)) ? fill_r : fill_r + SW'(1);
      if (LOAD) begin
         pat_d_s  = PAT_IN;
         hist_d_s = '0;
         fill_d_s = '0;
         s_d_s    = '0;
      end else if (EN) begin
         hit_s = (fill_nx_s == SW'(LEN)) && (hist_nx_s == pat_r);
         f_d_s = hit_s;
         if ((OVERLAP == 0) && hit_s) begin
            hist_d_s = '0;
            fill_d_s = '0;
         end else begin
            hist_d_s = hist_nx_s;
            fill_d_s = fill_nx_s;
         end
         s_d_s = progress(hist_d_s, pat_r, fill_d_s);
      end else begin
         f_d_s = 1'b0;
      end
   end

   // Detection state registers.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         pat_r  <= RST_PAT;
         hist_r <= '0;
         fill_r <= '0;
         s_r    <= '0;
         f_r    <= 1'b0;
      end else begin
         pat_r  <= pat_d_s;
         hist_r <= hist_d_s;
         fill_r <= fill_d_s;
         s_r    <= s_d_s;
         f_r    <= f_d_s;
      end
   end

   // Saturating match counter; clear beats a simultaneous hit.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         count_r <= '0;
         sat_r   <= 1'b0;
      end else if (CLR_CNT) begin
         count_r <= '0;
         sat_r   <= 1'b0;
      end else if (hit_s && !sat_r) begin
         count_r <= count_r + CNT_W'(1);
         sat_r   <= ((count_r + CNT_W'(1)) == {CNT_W{1'b1}});
      end else begin
         count_r <= count_r;
         sat_r   <= sat_r;
      end
   end

   assign F     = f_r;
   assign S     = s_r;
   assign COUNT = count_r;
   assign SAT   = sat_r;

endmodule
